// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end: datapath width,
// sequential PC step, fetch FSM states and the fetch-to-decode bundle.
package mips_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
    } if_bundle_t;

endpackage

// File: rtl/pc_incr.sv
// Combinational PC incrementer: pc + STEP, modulo 2^XLEN, no carry out.
module pc_incr
    import mips_pkg::*;
#(
    parameter int unsigned STEP = PC_STEP
) (
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_next_o
);

    assign pc_next_o = pc_i + XLEN'(STEP);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch with redirect/squash.
// Optional macro PC_MISALIGN_TRAP_EN adds a sticky misalign_err trap output.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = mips_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
`ifdef PC_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            if_valid_q, if_valid_d;
    if_bundle_t      if_q, if_d;
    logic [XLEN-1:0] pc_step;

    logic parked;
    logic trap_hit;
    logic redirect_take;
    logic redirect_keeps_wait;

    pc_incr #(
        .STEP (PC_STEP)
    ) u_pc_incr (
        .pc_i      (pc_q),
        .pc_next_o (pc_step)
    );

`ifdef PC_MISALIGN_TRAP_EN
    logic trap_q;

    assign parked        = trap_q;
    assign trap_hit      = redirect_valid && !trap_q && (redirect_target[1:0] != 2'b00);
    assign redirect_take = redirect_valid && !trap_q && (redirect_target[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else if (trap_hit) begin
            trap_q <= 1'b1;
        end
    end
`else
    assign parked        = 1'b0;
    assign trap_hit      = 1'b0;
    assign redirect_take = redirect_valid;
`endif

    // A redirect landing on a request that is (or was just) granted must wait
    // for that response and throw it away; everything else refetches at once.
    assign redirect_keeps_wait = ((state_q == S_REQ) && imem_gnt) ||
                                 ((state_q == S_WAIT) && !imem_rvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (imem_gnt)    state_d = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_d = drop_q ? S_REQ : S_HOLD;
            S_HOLD:  if (if_ready)    state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
        if (redirect_take) begin
            state_d = redirect_keeps_wait ? S_WAIT : S_REQ;
        end
        if (parked || trap_hit) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        drop_d     = drop_q;
        if_valid_d = if_valid_q;
        if_d       = if_q;
        case (state_q)
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        if_d.pc       = pc_q;
                        if_d.instr    = imem_rdata;
                        if_d.pc_plus4 = pc_step;
                        if_valid_d    = 1'b1;
                        pc_d          = pc_step;
                    end
                end
            end
            S_HOLD: begin
                if (if_ready) begin
                    if_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (redirect_take) begin
            pc_d       = redirect_target;
            drop_d     = redirect_keeps_wait;
            if_valid_d = 1'b0;
            if_d       = if_q;
        end
        if (trap_hit) begin
            pc_d       = pc_q;
            drop_d     = 1'b0;
            if_valid_d = 1'b0;
            if_d       = if_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_q       <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            if_valid_q <= if_valid_d;
            if_q       <= if_d;
        end
    end

    always_comb begin
        imem_req    = (state_q == S_REQ);
        imem_addr   = pc_q;
        if_valid    = if_valid_q;
        if_pc       = if_q.pc;
        if_instr    = if_q.instr;
        if_pc_plus4 = if_q.pc_plus4;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_err = trap_q;
`endif
    end

endmodule
